// File: rtl/latch_phase_ctrl_if.sv
// Run-control and latch-phase bundle for latch_phase_ctrl.
// Run control drives the master side; the phase generator is the slave.
interface latch_phase_ctrl_if #(
  parameter int PH_W  = 4,
  parameter int CNT_W = 16
);
  logic             run;
  logic             step;
  logic [PH_W-1:0]  ph_len;
  logic [PH_W-1:0]  gap_len;
  logic             phi1;
  logic             phi2;
  logic             lat_rst;
  logic             busy;
  logic             step_done;
  logic [CNT_W-1:0] cyc_cnt;

  modport master (
    output run, step, ph_len, gap_len,
    input  phi1, phi2, lat_rst, busy, step_done, cyc_cnt
  );

  modport slave (
    input  run, step, ph_len, gap_len,
    output phi1, phi2, lat_rst, busy, step_done, cyc_cnt
  );
endinterface

// File: rtl/latch_phase_ctrl.sv
// Non-overlapping phi1/phi2 latch-enable generator with
// post-reset flush of both latch ranks and run/step control.
module latch_phase_ctrl #(
  parameter int PH_W  = 4,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  latch_phase_ctrl_if.slave bus
);
  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_FL1  = 3'd1;
  localparam logic [2:0] S_FL2  = 3'd2;
  localparam logic [2:0] S_IDLE = 3'd3;
  localparam logic [2:0] S_PH1  = 3'd4;
  localparam logic [2:0] S_GAP1 = 3'd5;
  localparam logic [2:0] S_PH2  = 3'd6;
  localparam logic [2:0] S_GAP2 = 3'd7;

  localparam logic [PH_W-1:0] ONE = PH_W'(1);

  logic [2:0]      state, nstate;
  logic [PH_W-1:0] cnt, ncnt;
  logic [PH_W-1:0] p_len, g_len;
  logic [PH_W-1:0] np, ng;
  logic            mode, nmode;
  logic            step_q;
  logic            step_rise;
  logic            cap;
  logic            done;
  logic            inc;

  assign step_rise = bus.step & ~step_q;
  assign np = (bus.ph_len  == '0) ? ONE : bus.ph_len;
  assign ng = (bus.gap_len == '0) ? ONE : bus.gap_len;

  // Next state; cnt holds remaining cycles of the current phase minus one.
  // mode: 0 = free-running, 1 = single step.
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nmode  = mode;
    cap    = 1'b0;
    done   = 1'b0;
    inc    = 1'b0;
    unique case (state)
      S_RST:  nstate = S_FL1;
      S_FL1:  nstate = S_FL2;
      S_FL2:  nstate = S_IDLE;
      S_IDLE: begin
        if (bus.run) begin
          nstate = S_PH1;
          nmode  = 1'b0;
          cap    = 1'b1;
        end else if (step_rise) begin
          nstate = S_PH1;
          nmode  = 1'b1;
          cap    = 1'b1;
        end
      end
      S_PH1: begin
        if (cnt == '0) begin
          nstate = S_GAP1;
          ncnt   = g_len - ONE;
        end else begin
          ncnt = cnt - ONE;
        end
      end
      S_GAP1: begin
        if (cnt == '0) begin
          nstate = S_PH2;
          ncnt   = p_len - ONE;
        end else begin
          ncnt = cnt - ONE;
        end
      end
      S_PH2: begin
        if (cnt == '0) begin
          nstate = S_GAP2;
          ncnt   = g_len - ONE;
        end else begin
          ncnt = cnt - ONE;
        end
      end
      S_GAP2: begin
        if (cnt == '0) begin
          inc = 1'b1;
          if (!mode && bus.run) begin
            nstate = S_PH1;
            cap    = 1'b1;
          end else begin
            nstate = S_IDLE;
            done   = mode;
          end
        end else begin
          ncnt = cnt - ONE;
        end
      end
      default: nstate = S_RST;
    endcase
    if (cap) ncnt = np - ONE;
  end

  // State, shadow lengths and outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_RST;
      cnt           <= '0;
      mode          <= 1'b0;
      step_q        <= 1'b0;
      p_len         <= ONE;
      g_len         <= ONE;
      bus.phi1      <= 1'b0;
      bus.phi2      <= 1'b0;
      bus.lat_rst   <= 1'b0;
      bus.busy      <= 1'b1;
      bus.step_done <= 1'b0;
      bus.cyc_cnt   <= '0;
    end else begin
      state  <= nstate;
      cnt    <= ncnt;
      mode   <= nmode;
      step_q <= bus.step;
      if (cap) begin
        p_len <= np;
        g_len <= ng;
      end
      if (inc) bus.cyc_cnt <= bus.cyc_cnt + CNT_W'(1);
      bus.phi1      <= (nstate == S_PH1) || (nstate == S_FL1);
      bus.phi2      <= (nstate == S_PH2) || (nstate == S_FL2);
      bus.lat_rst   <= (nstate == S_FL1) || (nstate == S_FL2);
      bus.busy      <= (nstate != S_IDLE);
      bus.step_done <= done;
    end
  end
endmodule

// File: tb/tb_latch_phase_ctrl.sv
// Scoreboard bench for latch_phase_ctrl: a cycle-plan reference
// model queues expected outputs, a negedge monitor compares.
module tb_latch_phase_ctrl;
  localparam int PH_W  = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  latch_phase_ctrl_if #(.PH_W(PH_W), .CNT_W(CNT_W)) bus ();

  latch_phase_ctrl #(.PH_W(PH_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic             phi1;
    logic             phi2;
    logic             lat;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  // plan entries: {phi1, phi2, lat_rst, busy} per future clk cycle
  logic [3:0] plan[$];
  obs_t       sb[$];

  int compared   = 0;
  int mismatched = 0;
  int cycles     = 0;
  bit rst_pend   = 1'b0;
  bit active     = 1'b0;
  bit step_mode  = 1'b0;
  bit sq         = 1'b0;

  task automatic start(bit stp);
    int p, g;
    p = (bus.ph_len  == 0) ? 1 : int'(bus.ph_len);
    g = (bus.gap_len == 0) ? 1 : int'(bus.gap_len);
    for (int i = 0; i < p; i++) plan.push_back(4'b1001);
    for (int i = 0; i < g; i++) plan.push_back(4'b0001);
    for (int i = 0; i < p; i++) plan.push_back(4'b0101);
    for (int i = 0; i < g; i++) plan.push_back(4'b0001);
    active    = 1'b1;
    step_mode = stp;
  endtask

  task automatic model_edge();
    obs_t       e;
    logic [3:0] o;
    bit         done;
    bit         rise;
    done = 1'b0;
    if (!rst) begin
      plan.delete();
      active   = 1'b0;
      sq       = 1'b0;
      cycles   = 0;
      rst_pend = 1'b1;
      e        = '0;
      e.busy   = 1'b1;
      sb.push_back(e);
      return;
    end
    rise = bus.step && !sq;
    sq   = bus.step;
    if (rst_pend) begin
      plan.push_back(4'b1011);
      plan.push_back(4'b0111);
      plan.push_back(4'b0000);
      rst_pend = 1'b0;
    end
    if (plan.size() == 0) begin
      if (active) begin
        active = 1'b0;
        cycles++;
        if (step_mode) done = 1'b1;
        else if (bus.run) start(1'b0);
      end else if (bus.run) begin
        start(1'b0);
      end else if (rise) begin
        start(1'b1);
      end
    end
    o      = (plan.size() != 0) ? plan.pop_front() : 4'b0000;
    e.phi1 = o[3];
    e.phi2 = o[2];
    e.lat  = o[1];
    e.busy = o[0];
    e.done = done;
    e.cnt  = CNT_W'(cycles);
    sb.push_back(e);
  endtask

  task automatic drive(bit r, bit s, int p, int g, bit rs, int n);
    repeat (n) begin
      bus.run     = r;
      bus.step    = s;
      bus.ph_len  = PH_W'(p);
      bus.gap_len = PH_W'(g);
      rst         = rs;
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  // Monitor: compare every observed cycle against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      obs_t x, a;
      x      = sb.pop_front();
      a.phi1 = bus.phi1;
      a.phi2 = bus.phi2;
      a.lat  = bus.lat_rst;
      a.busy = bus.busy;
      a.done = bus.step_done;
      a.cnt  = bus.cyc_cnt;
      compared++;
      if (a !== x) begin
        mismatched++;
        $display("FAIL outputs t=%0t got p1=%b p2=%b lr=%b bz=%b sd=%b cc=%0d want p1=%b p2=%b lr=%b bz=%b sd=%b cc=%0d",
                 $time, a.phi1, a.phi2, a.lat, a.busy, a.done, a.cnt,
                 x.phi1, x.phi2, x.lat, x.busy, x.done, x.cnt);
      end
    end
  end

  initial begin
    bus.run     = 1'b0;
    bus.step    = 1'b0;
    bus.ph_len  = '0;
    bus.gap_len = '0;
    // reset and flush
    drive(0, 0, 2, 1, 0, 3);
    drive(0, 0, 2, 1, 1, 6);
    // free run, 3 periods of 6
    drive(1, 0, 2, 1, 1, 18);
    drive(0, 0, 2, 1, 1, 8);
    // single step with a long step pulse
    drive(0, 1, 3, 2, 1, 5);
    drive(0, 0, 3, 2, 1, 14);
    // zero lengths, then ph_len change mid-cycle
    drive(1, 0, 0, 0, 1, 7);
    drive(1, 0, 4, 0, 1, 14);
    drive(0, 0, 4, 0, 1, 14);
    // run dropped during PH2
    drive(1, 0, 2, 1, 1, 4);
    drive(0, 0, 2, 1, 1, 8);
    // reset mid-PH1, then 16+ cycles to wrap the counter
    drive(1, 0, 3, 1, 1, 2);
    drive(1, 0, 3, 1, 0, 2);
    drive(1, 0, 0, 0, 1, 70);
    drive(0, 0, 0, 0, 1, 6);
    // randomized run/step/length/reset mix
    repeat (1500) begin
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 199) != 0, 1);
    end
    drive(0, 0, 1, 1, 1, 20);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule

// File: doc/latch_phase_ctrl.md
Name: latch_phase_ctrl

Overview:
- Generates two non-overlapping latch-enable phases, phi1 and phi2, for the team's master/slave LATCH pipeline ranks. Also generates the shared latch clear, lat_rst.
- Runs free, runs one cycle per step, or sits idle. Phase width and dead-time (gap) width are programmable.
- After every reset it performs a flush sequence that clears both latch ranks.
- Sits between the top-level run control and every LATCH instance's clk/rst inputs.

Parameters:
- PH_W, 4, bit width of the ph_len and gap_len inputs and of the internal phase counter.
- CNT_W, 16, bit width of the completed-cycle counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset).
- run  input  1  level; 1 = free-running phase generation.
- step  input  1  a rising edge (0→1) requests exactly one full phi1/phi2 cycle.
- ph_len  input  PH_W  phase high time in clk cycles; 0 is treated as 1.
- gap_len  input  PH_W  dead time after each phase in clk cycles; 0 is treated as 1.
- phi1  output  1  enable for the master latch rank.
- phi2  output  1  enable for the slave latch rank.
- lat_rst  output  1  active-high clear to all LATCH rst inputs.
- busy  output  1  1 whenever the state is not IDLE.
- step_done  output  1  one-cycle pulse when a stepped cycle completes.
- cyc_cnt  output  CNT_W  count of completed phi1/phi2 cycles; wraps around.

Behaviour:
- Outputs: all outputs are registered, with no combinational path from inputs to outputs.
- Reset: any clk edge with rst=0 forces the following, regardless of state, overriding everything including mid-cycle operation:
  - state=RST, phi1=0, phi2=0, lat_rst=0, busy=1, step_done=0, cyc_cnt=0, step edge register=0.
- States: RST, FL1, FL2, IDLE, PH1, GAP1, PH2, GAP2.
- Flush sequence:
  - First edge with rst=1 enters FL1: phi1=1, lat_rst=1.
  - Next edge enters FL2: phi1=0, phi2=1, lat_rst=1.
  - Next edge enters IDLE: phi1, phi2 and lat_rst all 0; busy=0.
  - lat_rst is 1 only in FL1 and FL2.
- Step detection: step_rise = step & ~step_q, where step_q is registered every cycle.
  - step_rise is acted on only in IDLE and is discarded in every other state; step requests are not queued.
- Leaving IDLE:
  - run=1 at an edge → PH1, mode=RUN.
  - Otherwise, step_rise=1 → PH1, mode=STEP.
  - run has priority over step.
- Length capture: on IDLE→PH1 and GAP2→PH1, capture P = max(ph_len,1) and G = max(gap_len,1) into shadow registers.
  - ph_len and gap_len changes mid-cycle take effect only at the next cycle start.
- Phase sequence: PH1 (phi1=1) lasts P cycles, GAP1 (both 0) lasts G cycles, PH2 (phi2=1) lasts P cycles, GAP2 (both 0) lasts G cycles.
  - Period = 2(P+G) clk cycles.
  - phi1 and phi2 are never 1 simultaneously outside FL1/FL2, and never both 1 there either.
- End of GAP2:
  - cyc_cnt increments by 1, modulo 2^CNT_W.
  - mode=RUN and run=1 → PH1 with no idle cycle.
  - mode=RUN and run=0 → IDLE.
  - mode=STEP → IDLE, with step_done=1 for the first IDLE cycle only.
- run dropping: when run drops mid-cycle, the current cycle always completes; no phase is truncated.
- run asserting during a STEP cycle: the cycle completes as STEP, then IDLE samples run at its first edge.

Test Plan:
- Reset flush: rst=0 for 3 cycles, then 1 → phi1=1 with lat_rst=1 for 1 cycle, then phi2=1 with lat_rst=1 for 1 cycle, then IDLE with busy=0 and cyc_cnt=0.
- Free run: ph_len=2, gap_len=1, run=1 for 3 periods → phi1 pattern 110000 and phi2 pattern 000110 repeating every 6 cycles; cyc_cnt reads 1, 2, 3 at each period boundary; never phi1&phi2.
- Single step: run=0, step pulsed high for 5 cycles, ph_len=3, gap_len=2 → exactly one 10-cycle cycle; step_done=1 for 1 cycle; cyc_cnt=1; no second cycle.
- Zero lengths and mid-cycle change: ph_len=0, gap_len=0 → period 4 (1/1/1/1); set ph_len=4 during PH2 → that cycle unchanged, next cycle phi1 high for 4 cycles.
- Run drop mid-PH2: run=0 while in PH2 (ph_len=2, gap_len=1) → PH2 and GAP2 complete, IDLE follows, cyc_cnt increments once.
- Reset mid-operation plus wrap: rst=0 during PH1 → next edge phi1=0, flush sequence repeats after release. With CNT_W=4, 16 run cycles → cyc_cnt returns to 0.
